// File: rtl/alu_ctrl_seq_if.sv
// ALU control request/response bundle: requester drives in_valid/alu_op/func,
// unit returns in_ready, decoded alu_ctrl/illegal and the MDU sequencing strobes.
interface alu_ctrl_seq_if #(
  parameter int FUNC_W = 4,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [FUNC_W-1:0] func;
  logic              out_valid;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              mdu_start;
  logic              mdu_op;
  logic              mdu_busy;
  logic              mdu_done;

  modport master (
    output in_valid, alu_op, func,
    input  in_ready, out_valid, alu_ctrl, illegal,
    input  mdu_start, mdu_op, mdu_busy, mdu_done
  );

  modport slave (
    input  in_valid, alu_op, func,
    output in_ready, out_valid, alu_ctrl, illegal,
    output mdu_start, mdu_op, mdu_busy, mdu_done
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control with multi-cycle MULT/DIV sequencing (IDLE/RUN FSM).
// Ports: clk, rst_n (async low), flush (sync abort), bus (slave side).
module alu_ctrl_seq #(
  parameter int FUNC_W     = 4,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_ctrl_seq_if.slave bus
);
  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ?
                         MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic { IDLE, RUN } state_t;

  state_t            st, st_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ov_q, ov_n;
  logic [CTRL_W-1:0] ctrl_q, ctrl_n;
  logic              ill_q, ill_n;
  logic              start_q, start_n;
  logic              op_q, op_n;
  logic              done_q, done_n;

  logic              hi_bad;
  logic [3:0]        dec_code;
  logic              dec_ill;
  logic              dec_mdu;
  logic              dec_div;

  if (FUNC_W > 4) begin : g_hi
    assign hi_bad = |bus.func[FUNC_W-1:4];
  end else begin : g_nohi
    assign hi_bad = 1'b0;
  end

  always_comb begin
    dec_code = 4'd0;
    dec_ill  = 1'b0;
    dec_mdu  = 1'b0;
    dec_div  = 1'b0;
    unique case (1'b1)
      bus.alu_op == 2'b11: dec_code = 4'd0;
      bus.alu_op == 2'b10: dec_code = 4'd1;
      bus.alu_op == 2'b01: dec_code = 4'd2;
      default: begin
        if (hi_bad || bus.func[3:0] > 4'd10) begin
          dec_ill = 1'b1;
        end else begin
          dec_code = bus.func[3:0];
          dec_mdu  = bus.func[3:0] >= 4'd9;
          dec_div  = bus.func[3:0] == 4'd10;
        end
      end
    endcase
  end

  // cnt holds the RUN cycles still to go, including the current one
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    ov_n    = 1'b0;
    ctrl_n  = ctrl_q;
    ill_n   = 1'b0;
    start_n = 1'b0;
    op_n    = op_q;
    done_n  = 1'b0;
    if (flush) begin
      st_n   = IDLE;
      cnt_n  = '0;
      ctrl_n = '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            if (dec_mdu) begin
              st_n    = RUN;
              cnt_n   = dec_div ? DIV_LD : MUL_LD;
              start_n = 1'b1;
              op_n    = dec_div;
            end else begin
              ov_n   = 1'b1;
              ctrl_n = CTRL_W'(dec_code);
              ill_n  = dec_ill;
            end
          end
        end
        RUN: begin
          if (cnt <= CNT_W'(1)) begin
            st_n   = IDLE;
            cnt_n  = '0;
            ov_n   = 1'b1;
            done_n = 1'b1;
            ctrl_n = op_q ? CTRL_W'(10) : CTRL_W'(9);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      ov_q    <= 1'b0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      ov_q    <= ov_n;
      ctrl_q  <= ctrl_n;
      ill_q   <= ill_n;
      start_q <= start_n;
      op_q    <= op_n;
      done_q  <= done_n;
    end
  end

  assign bus.in_ready  = (st == IDLE);
  assign bus.mdu_busy  = (st == RUN);
  assign bus.out_valid = ov_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = ill_q;
  assign bus.mdu_start = start_q;
  assign bus.mdu_op    = op_q;
  assign bus.mdu_done  = done_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: timeline reference model,
// directed scenarios with literal checks, then randomized traffic.
module tb_alu_ctrl_seq;
  localparam int FW = 5;
  localparam int CW = 4;
  localparam int MC = 4;
  localparam int DC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_ctrl_seq_if #(.FUNC_W(FW), .CTRL_W(CW)) bus();

  alu_ctrl_seq #(
    .FUNC_W(FW), .CTRL_W(CW),
    .MUL_CYCLES(MC), .DIV_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: an accepted MDU op is an absolute timeline
  bit m_act;
  int m_t;
  int m_n;
  bit m_div;
  bit m_op;
  bit s_hit;
  int s_code;
  bit s_ill;
  bit fl_prev;
  int last_ctrl;
  bit exp_ready;
  bit acc;

  task automatic cmp(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input int op, input int f,
                                     output int code, output bit ill,
                                     output bit mdu);
    ill = 1'b0;
    mdu = 1'b0;
    if (op == 3) code = 0;
    else if (op == 2) code = 1;
    else if (op == 1) code = 2;
    else if (f > 10) begin
      code = 0;
      ill  = 1'b1;
    end else begin
      code = f;
      mdu  = (f == 9) || (f == 10);
    end
  endfunction

  task automatic model_reset();
    m_act     = 1'b0;
    s_hit     = 1'b0;
    fl_prev   = 1'b0;
    last_ctrl = 0;
    m_op      = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic check_cycle();
    bit e_busy, e_start, e_done, e_ov, e_ill;
    int e_ctrl;
    e_busy  = m_act && cyc > m_t && cyc < m_t + m_n;
    e_start = m_act && cyc == m_t + 1;
    e_done  = m_act && cyc == m_t + m_n;
    e_ov    = e_done || s_hit;
    e_ill   = s_hit && s_ill;
    if (e_done) e_ctrl = m_div ? 10 : 9;
    else if (s_hit) e_ctrl = s_code;
    else if (fl_prev) e_ctrl = 0;
    else e_ctrl = last_ctrl;
    cmp("in_ready", int'(bus.in_ready), int'(!e_busy));
    cmp("out_valid", int'(bus.out_valid), int'(e_ov));
    cmp("alu_ctrl", int'(bus.alu_ctrl), e_ctrl);
    cmp("illegal", int'(bus.illegal), int'(e_ill));
    cmp("mdu_start", int'(bus.mdu_start), int'(e_start));
    cmp("mdu_busy", int'(bus.mdu_busy), int'(e_busy));
    cmp("mdu_done", int'(bus.mdu_done), int'(e_done));
    cmp("mdu_op", int'(bus.mdu_op), int'(m_op));
    last_ctrl = e_ctrl;
    if (e_done) m_act = 1'b0;
    exp_ready = !e_busy;
  endtask

  task automatic model_update(input bit v, input int op, input int f,
                              input bit fl);
    int code;
    bit ill, mdu;
    fl_prev = fl;
    s_hit   = 1'b0;
    acc     = 1'b0;
    if (fl) begin
      m_act = 1'b0;
    end else if (v && exp_ready) begin
      acc = 1'b1;
      ref_decode(op, f, code, ill, mdu);
      if (mdu) begin
        m_act = 1'b1;
        m_t   = cyc;
        m_div = (code == 10);
        m_n   = m_div ? DC : MC;
        m_op  = m_div;
      end else begin
        s_hit  = 1'b1;
        s_code = code;
        s_ill  = ill;
      end
    end
  endtask

  task automatic step(input bit v, input int op, input int f,
                      input bit fl);
    logic [1:0] o2;
    logic [FW-1:0] fv;
    o2 = op[1:0];
    fv = f[FW-1:0];
    @(negedge clk);
    check_cycle();
    bus.in_valid = v;
    bus.alu_op   = o2;
    bus.func     = fv;
    flush        = fl;
    model_update(v, op, f, fl);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    bit pv, pacc, pfl, v, fl;
    int ho, hf;
    bus.in_valid = 1'b0;
    bus.alu_op   = 2'b00;
    bus.func     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("rst_in_ready", int'(bus.in_ready), 1);
    cmp("rst_out_valid", int'(bus.out_valid), 0);
    cmp("rst_alu_ctrl", int'(bus.alu_ctrl), 0);
    cmp("rst_mdu_busy", int'(bus.mdu_busy), 0);
    rst_n = 1'b1;

    // SLT, latency 1
    step(1'b1, 0, 4, 1'b0);
    idle();
    cmp("slt_ov", int'(bus.out_valid), 1);
    cmp("slt_ctrl", int'(bus.alu_ctrl), 4);
    cmp("slt_ill", int'(bus.illegal), 0);
    idle();
    cmp("slt_ov_off", int'(bus.out_valid), 0);

    // alu_op classes back to back
    step(1'b1, 3, 15, 1'b0);
    step(1'b1, 2, 15, 1'b0);
    cmp("add_ctrl", int'(bus.alu_ctrl), 0);
    step(1'b1, 1, 15, 1'b0);
    cmp("sub_ov", int'(bus.out_valid), 1);
    cmp("sub_ctrl", int'(bus.alu_ctrl), 1);
    idle();
    cmp("and_ov", int'(bus.out_valid), 1);
    cmp("and_ctrl", int'(bus.alu_ctrl), 2);

    // MULT
    step(1'b1, 0, 9, 1'b0);
    idle();
    cmp("mul_start", int'(bus.mdu_start), 1);
    cmp("mul_busy1", int'(bus.mdu_busy), 1);
    cmp("mul_rdy1", int'(bus.in_ready), 0);
    idle();
    cmp("mul_start2", int'(bus.mdu_start), 0);
    idle();
    cmp("mul_busy3", int'(bus.mdu_busy), 1);
    idle();
    cmp("mul_ov", int'(bus.out_valid), 1);
    cmp("mul_done", int'(bus.mdu_done), 1);
    cmp("mul_ctrl", int'(bus.alu_ctrl), 9);
    cmp("mul_busy4", int'(bus.mdu_busy), 0);

    // DIV with a held ADD behind it
    step(1'b1, 0, 10, 1'b0);
    repeat (7) step(1'b1, 3, 0, 1'b0);
    step(1'b1, 3, 0, 1'b0);
    cmp("div_done", int'(bus.mdu_done), 1);
    cmp("div_ctrl", int'(bus.alu_ctrl), 10);
    cmp("div_rdy", int'(bus.in_ready), 1);
    idle();
    cmp("add2_ov", int'(bus.out_valid), 1);
    cmp("add2_ctrl", int'(bus.alu_ctrl), 0);

    // illegal encodings
    step(1'b1, 0, 6, 1'b0);
    step(1'b1, 0, 12, 1'b0);
    step(1'b1, 0, 16, 1'b0);
    cmp("ill12_ov", int'(bus.out_valid), 1);
    cmp("ill12_ill", int'(bus.illegal), 1);
    cmp("ill12_ctrl", int'(bus.alu_ctrl), 0);
    idle();
    cmp("ill16_ill", int'(bus.illegal), 1);

    // flush in third DIV busy cycle
    step(1'b1, 0, 7, 1'b0);
    step(1'b1, 0, 10, 1'b0);
    idle();
    idle();
    step(1'b1, 3, 0, 1'b1);
    cmp("fl_busy3", int'(bus.mdu_busy), 1);
    idle();
    cmp("fl_busy", int'(bus.mdu_busy), 0);
    cmp("fl_rdy", int'(bus.in_ready), 1);
    cmp("fl_ctrl", int'(bus.alu_ctrl), 0);
    idle();
    cmp("fl_drop", int'(bus.out_valid), 0);
    repeat (6) idle();

    // flush drops a request even when ready
    step(1'b1, 0, 3, 1'b0);
    step(1'b1, 0, 5, 1'b1);
    idle();
    cmp("fli_ov", int'(bus.out_valid), 0);
    cmp("fli_ctrl", int'(bus.alu_ctrl), 0);

    // async reset mid-RUN
    step(1'b1, 0, 10, 1'b0);
    idle();
    idle();
    cmp("pre_rst_op", int'(bus.mdu_op), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_busy", int'(bus.mdu_busy), 0);
    cmp("arst_op", int'(bus.mdu_op), 0);
    cmp("arst_rdy", int'(bus.in_ready), 1);
    cmp("arst_ov", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) idle();

    // randomized traffic; requester holds until accepted
    pv = 1'b0; pacc = 1'b0; pfl = 1'b0;
    ho = 0; hf = 0;
    repeat (3000) begin
      if (pv && !pacc && !pfl) begin
        v = 1'b1;
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        ho = $urandom_range(0, 1) != 0 ? 0 : $urandom_range(0, 3);
        hf = $urandom_range(0, 15);
        if ($urandom_range(0, 5) == 0) hf = 9 + $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) hf += 16;
      end
      fl = ($urandom_range(0, 24) == 0);
      step(v, ho, hf, fl);
      pv = v; pacc = acc; pfl = fl;
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
